ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Parametrised successor to the pipeline's two-client memory controller.
- Arbitrates NPORTS word-wide requesters onto one narrow asynchronous SRAM: fixed-priority or round-robin.
- Splits each DATA_W word into BEATS = DATA_W/RAM_DATA_W RAM beats, sequencing addresses, strobes and the tri-state data bus.
- Sits between the fetch/memory stages (and any future clients) and the external RAM pins.

Parameters:
NPORTS, 2, number of requester channels (>=1)
DATA_W, 32, requester word width
RAM_DATA_W, 16, RAM data bus width; DATA_W/RAM_DATA_W is a power of 2, >=1
RAM_ADDR_W, 18, RAM address width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
Derived: BEATS = DATA_W/RAM_DATA_W; BW = log2(BEATS); ADDR_W = RAM_ADDR_W - BW

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
req_en  in  NPORTS  per-port request
req_rw  in  NPORTS  per-port 1 = write, 0 = read
req_addr  in  NPORTS*ADDR_W  word addresses; port i in slice i
req_wdata  in  NPORTS*DATA_W  write data; port i in slice i
ack  out  NPORTS  one-cycle completion pulse, one-hot
rdata  out  DATA_W  read data of last completed read
busy  out  1  high in any state except IDLE
ram_addr  out  RAM_ADDR_W  RAM address
ram_data  inout  RAM_DATA_W  RAM data, driven only during write states
ram_we_n  out  1  write enable, active low
ram_oe_n  out  1  output enable, active low
ram_ce_n  out  1  chip enable, active low
ram_hb_n, ram_lb_n  out  1 each  byte masks, active low, 0 whenever ram_ce_n = 0, else 1

Behaviour:
- Reset (reset = 0 at an edge), including mid-transaction:
  - state IDLE; ack = 0; rdata = 0; busy = 0.
  - ram_ce_n = ram_oe_n = ram_we_n = 1; ram_data high-Z; ram_addr = 0.
  - RR pointer = NPORTS-1, so port 0 wins first.
  - An aborted write may leave partial beats in RAM; no ack is issued.
- FSM states: IDLE, READ, WSETUP, WPULSE, DONE. Beat counter is BW bits wide (absent if BEATS = 1).
- IDLE:
  - If any req_en is set, select grant g:
    - ARB_MODE 0: lowest index.
    - ARB_MODE 1: first requesting port cyclically after pointer; pointer <= g.
  - Latch addr, rw, wdata of port g; beat = 0; go to READ (rw = 0) or WSETUP (rw = 1).
- READ, one cycle per beat:
  - ram_addr = {addr, beat}; ram_ce_n = 0; ram_oe_n = 0.
  - At the edge, capture ram_data into rdata slice [beat*RAM_DATA_W +: RAM_DATA_W] (beat 0 = LSBs).
  - Last beat -> DONE; otherwise beat++.
- WSETUP: ram_addr = {addr, beat}; ram_ce_n = 0; ram_we_n = 1; ram_data driven with the beat slice -> WPULSE.
- WPULSE: same address and data; ram_we_n = 0. Last beat -> DONE; otherwise beat++ -> WSETUP.
  - Address and data are stable across both edges of every we_n pulse.
- DONE:
  - ack[g] = 1 for exactly this cycle; strobes inactive; bus high-Z -> IDLE.
  - rdata is updated on reads only and holds its value until the next read completes.
- Latency, counted from the IDLE sampling edge to the ack cycle:
  - read: ack high BEATS+1 cycles later.
  - write: ack high 2*BEATS+1 cycles later.
- Throughput: one read per BEATS+2 cycles.
- Handshake:
  - Requester holds req_en and fields until it samples ack, then drops req_en at that edge.
  - If req_en is still high in IDLE afterwards, it is a new request.
  - Field changes after grant are ignored (values are latched).
- Simultaneous requests: exactly one grant per IDLE cycle; losers wait, no starvation in mode 1.
- Address wrap: none; the top word maps to the top RAM beats.
- BEATS = 1: READ and WPULSE each last one cycle; beat counter absent.

Test Plan:
- Read, port 0, addr 0x00010; RAM[0x00020] = 0x1234, RAM[0x00021] = 0xABCD -> ack[0] three cycles after the sampling edge; rdata = 0xABCD1234; ram_we_n stays 1.
- Write, port 1, addr 0x1FFFF, wdata 0xDEADBEEF -> RAM[0x3FFFE] = 0xBEEF, RAM[0x3FFFF] = 0xDEAD; ram_we_n low in two separate single cycles; ack[1] five cycles after sampling; bus high-Z otherwise.
- ARB_MODE 0, ports 0 and 1 both request reads -> port 0 acked first, port 1 acked BEATS+2 cycles later; with both held continuously, port 1 starves.
- ARB_MODE 1, NPORTS = 3, ports 0 and 2 re-requesting continuously, port 1 idle -> grant sequence 0, 2, 0, 2; ack is never multi-hot.
- reset = 0 during WSETUP of beat 1 -> next cycle: IDLE, all strobes 1, ram_data high-Z, busy 0, no ack; RAM holds only beat 0.
- Back-to-back reads, port 0 at 0x00000 then 0x00001 -> acks spaced exactly 4 cycles; rdata updates only in ack cycles.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for ram_port_arbiter.
// Packed per-port request fields, one-hot ack, shared read data.
interface ram_port_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17
);
  logic [NPORTS-1:0]        req_en;
  logic [NPORTS-1:0]        req_rw;
  logic [NPORTS*ADDR_W-1:0] req_addr;
  logic [NPORTS*DATA_W-1:0] req_wdata;
  logic [NPORTS-1:0]        ack;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;

  modport master (
    output req_en, req_rw, req_addr, req_wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req_en, req_rw, req_addr, req_wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// N-port arbiter onto a narrow async SRAM.
// Each requester word is split into BEATS RAM beats.
module ram_port_arbiter #(
  parameter int NPORTS     = 2,
  parameter int DATA_W     = 32,
  parameter int RAM_DATA_W = 16,
  parameter int RAM_ADDR_W = 18,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  ram_port_arbiter_if.slave     bus,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  inout  wire  [RAM_DATA_W-1:0] ram_data,
  output logic                  ram_we_n,
  output logic                  ram_oe_n,
  output logic                  ram_ce_n,
  output logic                  ram_hb_n,
  output logic                  ram_lb_n
);
  localparam int BEATS  = DATA_W / RAM_DATA_W;
  localparam int BW     = $clog2(BEATS);
  localparam int BCW    = (BW > 0) ? BW : 1;
  localparam int ADDR_W = RAM_ADDR_W - BW;
  localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WSETUP,
    S_WPULSE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_gnt;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       w_grant;
  logic                w_any;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_shadow;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   w_word;
  logic [NPORTS-1:0]   r_ack;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic                r_drv;
  logic [BCW-1:0]      w_beat;
  logic                w_last;
  logic                w_beat_inc;
  logic                w_beat_clr;
  logic                w_latch;

  assign w_any = |bus.req_en;

  // Pick the winning port: lowest index, or first after the RR pointer
  always_comb begin
    int j;
    j = 0;
    w_grant = '0;
    if (ARB_MODE == 0) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (bus.req_en[PW'(i)]) w_grant = PW'(i);
      end
    end else begin
      for (int k = NPORTS; k >= 1; k--) begin
        j = (int'(r_ptr) + k) % NPORTS;
        if (bus.req_en[PW'(j)]) w_grant = PW'(j);
      end
    end
  end

  // Beat counter and RAM address; no counter when a word is one beat
  generate
    if (BW > 0) begin : g_beat
      logic [BW-1:0] r_beat;
      // Step through the beats of the current word
      always_ff @(posedge clock) begin
        if (!reset) r_beat <= '0;
        else if (w_beat_clr) r_beat <= '0;
        else if (w_beat_inc) r_beat <= r_beat + 1'b1;
      end
      assign w_beat   = r_beat;
      assign w_last   = (r_beat == BW'(BEATS - 1));
      assign ram_addr = {r_addr, r_beat};
    end else begin : g_nobeat
      logic w_unused_beat;
      assign w_unused_beat = w_beat_inc | w_beat_clr;
      assign w_beat        = '0;
      assign w_last        = 1'b1;
      assign ram_addr      = r_addr;
    end
  endgenerate

  // Next state and beat sequencing
  always_comb begin
    w_next     = r_state;
    w_beat_inc = 1'b0;
    w_beat_clr = 1'b0;
    w_latch    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_latch    = 1'b1;
          w_beat_clr = 1'b1;
          w_next     = bus.req_rw[w_grant] ? S_WSETUP : S_READ;
        end
      end
      S_READ: begin
        if (w_last) w_next = S_DONE;
        else w_beat_inc = 1'b1;
      end
      S_WSETUP: w_next = S_WPULSE;
      S_WPULSE: begin
        if (w_last) w_next = S_DONE;
        else begin
          w_beat_inc = 1'b1;
          w_next     = S_WSETUP;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus the latched request of the granted port
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= PW'(NPORTS - 1);
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_gnt   <= w_grant;
        r_ptr   <= w_grant;
        r_addr  <= bus.req_addr[w_grant*ADDR_W +: ADDR_W];
        r_wdata <= bus.req_wdata[w_grant*DATA_W +: DATA_W];
      end
    end
  end

  // Strobes, bus drive and ack come straight from flops to avoid glitches
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ce_n <= 1'b1;
      r_oe_n <= 1'b1;
      r_we_n <= 1'b1;
      r_drv  <= 1'b0;
      r_ack  <= '0;
    end else begin
      r_ce_n <= !(w_next == S_READ || w_next == S_WSETUP ||
                  w_next == S_WPULSE);
      r_oe_n <= (w_next != S_READ);
      r_we_n <= (w_next != S_WPULSE);
      r_drv  <= (w_next == S_WSETUP || w_next == S_WPULSE);
      r_ack  <= '0;
      if (w_next == S_DONE) r_ack[r_gnt] <= 1'b1;
    end
  end

  // Merge the current RAM beat into the partially assembled word
  always_comb begin
    w_word = r_shadow;
    w_word[w_beat*RAM_DATA_W +: RAM_DATA_W] = ram_data;
  end

  // Beats gather in a shadow so rdata only changes when a read completes
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_shadow <= '0;
      r_rdata  <= '0;
    end else if (r_state == S_READ) begin
      r_shadow <= w_word;
      if (w_last) r_rdata <= w_word;
    end
  end

  assign ram_data  = r_drv ? r_wdata[w_beat*RAM_DATA_W +: RAM_DATA_W]
                           : {RAM_DATA_W{1'bz}};
  assign ram_ce_n  = r_ce_n;
  assign ram_oe_n  = r_oe_n;
  assign ram_we_n  = r_we_n;
  assign ram_hb_n  = r_ce_n;
  assign ram_lb_n  = r_ce_n;
  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign bus.busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a fixed-priority 2-port
// instance on an SRAM model, and a 3-port round-robin instance.
module tb_ram_port_arbiter;
  localparam int DW    = 32;
  localparam int RW    = 16;
  localparam int RAW   = 18;
  localparam int AW    = 17;
  localparam int BEATS = DW / RW;
  localparam logic [RW-1:0] IDLE_PAT = 16'hC3C3;

  logic clock;
  logic reset;

  ram_port_arbiter_if #(.NPORTS(2), .DATA_W(DW), .ADDR_W(AW)) b0 ();
  ram_port_arbiter_if #(.NPORTS(3), .DATA_W(DW), .ADDR_W(AW)) b1 ();

  logic [RAW-1:0] ram_addr;
  wire  [RW-1:0]  ram_data;
  logic ram_we_n, ram_oe_n, ram_ce_n, ram_hb_n, ram_lb_n;

  logic [RAW-1:0] r1_addr;
  wire  [RW-1:0]  r1_data;
  logic r1_we_n, r1_oe_n, r1_ce_n, r1_hb_n, r1_lb_n;

  ram_port_arbiter #(
    .NPORTS(2), .DATA_W(DW), .RAM_DATA_W(RW),
    .RAM_ADDR_W(RAW), .ARB_MODE(0)
  ) u_dut (
    .clock(clock), .reset(reset), .bus(b0),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .ram_ce_n(ram_ce_n),
    .ram_hb_n(ram_hb_n), .ram_lb_n(ram_lb_n)
  );

  ram_port_arbiter #(
    .NPORTS(3), .DATA_W(DW), .RAM_DATA_W(RW),
    .RAM_ADDR_W(RAW), .ARB_MODE(1)
  ) u_rr (
    .clock(clock), .reset(reset), .bus(b1),
    .ram_addr(r1_addr), .ram_data(r1_data),
    .ram_we_n(r1_we_n), .ram_oe_n(r1_oe_n), .ram_ce_n(r1_ce_n),
    .ram_hb_n(r1_hb_n), .ram_lb_n(r1_lb_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: drives reads, and a fixed pattern whenever the chip
  // is deselected so a stray DUT driver shows up as corrupted data.
  logic [RW-1:0] mem [0:(1<<RAW)-1];
  logic          pl_en;
  logic [RAW-1:0] pl_a;
  logic [RW-1:0] pl_d;
  logic [RW-1:0] tb_rd;

  assign tb_rd = ram_ce_n ? IDLE_PAT : mem[ram_addr];
  assign ram_data = (ram_we_n && (ram_ce_n || !ram_oe_n)) ? tb_rd
                                                          : {RW{1'bz}};
  assign r1_data = r1_we_n ? r1_addr[RW-1:0] : {RW{1'bz}};

  always @(posedge clock) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!ram_ce_n && !ram_we_n) mem[ram_addr] <= ram_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [RAW-1:0] a, input logic [RW-1:0] d);
    @(negedge clock);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge clock);
    #1 pl_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (b0.busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("wait_idle", {31'd0, b0.busy}, 32'd0);
  endtask

  task automatic do_txn(input int p, input logic rw,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [1:0] av,
                        output int wes, output logic bsy1);
    @(negedge clock);
    b0.req_rw[p]               = rw;
    b0.req_addr[p*AW +: AW]    = a;
    b0.req_wdata[p*DW +: DW]   = d;
    b0.req_en[p]               = 1'b1;
    lat  = 0;
    av   = '0;
    wes  = 0;
    bsy1 = 1'b0;
    for (int c = 1; c <= 16 && lat == 0; c++) begin
      @(negedge clock);
      if (c == 1) bsy1 = b0.busy;
      if (!ram_we_n) wes++;
      if (b0.ack != '0) begin
        lat = c;
        av  = b0.ack;
      end
    end
    b0.req_en[p] = 1'b0;
  endtask

  typedef struct {
    int              port;
    logic            rw;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  vec_t vt [7];

  initial begin
    int lat, wes, exp_lat, first, second, n0, n1, multi, na, a1, a2;
    logic [1:0] av;
    logic bsy1;
    logic [DW-1:0] rd, exp_rd;
    int seq [4];
    int exp_seq [4];

    vt[0] = '{0, 1'b0, 17'h00010, 32'h0,        32'hABCD1234};
    vt[1] = '{1, 1'b1, 17'h1FFFF, 32'hDEADBEEF, 32'hABCD1234};
    vt[2] = '{1, 1'b0, 17'h1FFFF, 32'h0,        32'hDEADBEEF};
    vt[3] = '{0, 1'b1, 17'h00000, 32'h0BADF00D, 32'hDEADBEEF};
    vt[4] = '{0, 1'b0, 17'h00000, 32'h0,        32'h0BADF00D};
    vt[5] = '{1, 1'b1, 17'h0AAAA, 32'h12345678, 32'h0BADF00D};
    vt[6] = '{0, 1'b0, 17'h0AAAA, 32'h0,        32'h12345678};
    exp_seq = '{0, 2, 0, 2};

    pl_en = 1'b0;
    pl_a  = '0;
    pl_d  = '0;
    b0.req_en = '0;  b0.req_rw = '0;
    b0.req_addr = '0; b0.req_wdata = '0;
    b1.req_en = '0;  b1.req_rw = '0;
    b1.req_addr = '0; b1.req_wdata = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);

    chk("rst_ack", {30'd0, b0.ack}, 32'd0);
    chk("rst_rdata", b0.rdata, 32'd0);
    chk("rst_busy", {31'd0, b0.busy}, 32'd0);
    chk("rst_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    chk("rst_bytes", {30'd0, ram_hb_n, ram_lb_n}, 32'd3);
    chk("rst_addr", {14'd0, ram_addr}, 32'd0);
    chk("rst_hiz", {16'd0, ram_data}, {16'd0, IDLE_PAT});
    reset = 1'b1;

    preload(18'h00020, 16'h1234);
    preload(18'h00021, 16'hABCD);
    preload(18'h00002, 16'h5566);
    preload(18'h00003, 16'h7788);

    for (int v = 0; v < 7; v++) begin
      do_txn(vt[v].port, vt[v].rw, vt[v].addr, vt[v].wdata,
             lat, av, wes, bsy1);
      exp_lat = vt[v].rw ? 2*BEATS + 1 : BEATS + 1;
      chk($sformatf("v%0d_lat", v), lat, exp_lat);
      chk($sformatf("v%0d_ack", v), {30'd0, av},
          32'd1 << vt[v].port);
      chk($sformatf("v%0d_busy", v), {31'd0, bsy1}, 32'd1);
      chk($sformatf("v%0d_rdata", v), b0.rdata, vt[v].exp_rdata);
      chk($sformatf("v%0d_done_strb", v),
          {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
      chk($sformatf("v%0d_done_hiz", v), {16'd0, ram_data},
          {16'd0, IDLE_PAT});
      if (vt[v].rw) begin
        chk($sformatf("v%0d_we_pulses", v), wes, BEATS);
        chk($sformatf("v%0d_mem_lo", v),
            {16'd0, mem[{vt[v].addr, 1'b0}]},
            {16'd0, vt[v].wdata[15:0]});
        chk($sformatf("v%0d_mem_hi", v),
            {16'd0, mem[{vt[v].addr, 1'b1}]},
            {16'd0, vt[v].wdata[31:16]});
      end else begin
        chk($sformatf("v%0d_we_pulses", v), wes, 0);
      end
    end

    // Fixed priority: simultaneous reads, port 0 first
    @(negedge clock);
    b0.req_rw = 2'b00;
    b0.req_addr = {17'h1FFFF, 17'h00010};
    b0.req_en = 2'b11;
    first = 0;
    second = 0;
    rd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (b0.ack == 2'b01 && first == 0) begin
        first = c;
        b0.req_en[0] = 1'b0;
      end else if (b0.ack == 2'b10 && second == 0) begin
        second = c;
        rd = b0.rdata;
        b0.req_en[1] = 1'b0;
      end
    end
    b0.req_en = 2'b00;
    chk("arb_first_lat", first, BEATS + 1);
    chk("arb_second_gap", second - first, BEATS + 2);
    chk("arb_second_rdata", rd, 32'hDEADBEEF);
    wait_idle();

    // Fixed priority: both held, port 1 never served
    @(negedge clock);
    b0.req_en = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      if (b0.ack[0]) n0++;
      if (b0.ack[1]) n1++;
    end
    b0.req_en = 2'b00;
    chk("starve_p0_acks", n0, 6);
    chk("starve_p1_acks", n1, 0);
    wait_idle();

    // Back-to-back reads from port 0; rdata moves only in ack cycles
    @(negedge clock);
    b0.req_addr[AW-1:0] = 17'h00000;
    b0.req_en = 2'b01;
    a1 = 0;
    a2 = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c < 3)      exp_rd = 32'hABCD1234;
      else if (c < 7) exp_rd = 32'h0BADF00D;
      else            exp_rd = 32'h77885566;
      chk($sformatf("b2b_rdata_c%0d", c), b0.rdata, exp_rd);
      if (b0.ack[0]) begin
        if (a1 == 0) begin
          a1 = c;
          b0.req_addr[AW-1:0] = 17'h00001;
        end else begin
          a2 = c;
        end
      end
    end
    b0.req_en = 2'b00;
    chk("b2b_first", a1, BEATS + 1);
    chk("b2b_gap", a2 - a1, BEATS + 2);
    wait_idle();

    // Round robin, 3 ports, ports 0 and 2 always requesting
    @(negedge clock);
    b1.req_en = 3'b101;
    na = 0;
    multi = 0;
    seq = '{-1, -1, -1, -1};
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (b1.ack != '0) begin
        if (!$onehot(b1.ack)) multi++;
        else if (na < 4) begin
          for (int i = 0; i < 3; i++)
            if (b1.ack[i]) seq[na] = i;
          na++;
        end
      end
    end
    b1.req_en = 3'b000;
    chk("rr_count", na, 4);
    chk("rr_multi_hot", multi, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), seq[i], exp_seq[i]);

    // Reset in WSETUP of beat 1 aborts the write
    preload(18'h0A000, 16'h0000);
    preload(18'h0A001, 16'h7777);
    @(negedge clock);
    b0.req_rw = 2'b01;
    b0.req_addr[AW-1:0] = 17'h05000;
    b0.req_wdata[DW-1:0] = 32'h11112222;
    b0.req_en = 2'b01;
    repeat (3) @(negedge clock);
    chk("abort_wsetup_addr", {14'd0, ram_addr}, 32'h0000A001);
    chk("abort_wsetup_we", {31'd0, ram_we_n}, 32'd1);
    reset = 1'b0;
    b0.req_en = 2'b00;
    @(negedge clock);
    chk("abort_busy", {31'd0, b0.busy}, 32'd0);
    chk("abort_ack", {30'd0, b0.ack}, 32'd0);
    chk("abort_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    chk("abort_hiz", {16'd0, ram_data}, {16'd0, IDLE_PAT});
    chk("abort_addr", {14'd0, ram_addr}, 32'd0);
    chk("abort_rdata", b0.rdata, 32'd0);
    chk("abort_mem_b0", {16'd0, mem[18'h0A000]}, 32'h00002222);
    chk("abort_mem_b1", {16'd0, mem[18'h0A001]}, 32'h00007777);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
